dram_arbiter: RTL and testbench

Two-master arbiter placed between the Bridge's DRAM port and the 64 KB DRAM, letting a second bus master (DMA / program loader) share DRAM with the CPU. It grants one master at a time under round-robin with a bounded hold, muxes address, write-enable and write data to DRAM, and returns DRAM read data to the granted master. A saturating wait-cycle counter exposes contention for debug.

---
 rtl/dram_arbiter.sv | 123 ++++++++++++
 tb/tb_dram_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Two-master round-robin DRAM arbiter with bounded hold per owner and a
// saturating contention counter for debug visibility.
module dram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [15:0]       wait_cnt
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] wait_q, wait_d;

  assign m0_gnt   = (state_q == OWN0) & m0_req & ~cpu_rst;
  assign m1_gnt   = (state_q == OWN1) & m1_req & ~cpu_rst;
  assign m0_rdata = dram_rdata;
  assign m1_rdata = dram_rdata;
  assign wait_cnt = wait_q;

  always_comb begin
    dram_addr  = '0;
    dram_wdata = '0;
    dram_we    = 1'b0;
    case (state_q)
      OWN0: begin
        dram_addr  = m0_addr;
        dram_wdata = m0_wdata;
        dram_we    = m0_we & m0_gnt;
      end
      OWN1: begin
        dram_addr  = m1_addr;
        dram_wdata = m1_wdata;
        dram_we    = m1_we & m1_gnt;
      end
      default: ;
    endcase
  end

  // Any exit from ownership records the outgoing owner so the next tie favours the other.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        hold_d = 4'd0;
        if (m0_req && m1_req) state_d = last_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
          last_d  = 1'b0;
          hold_d  = 4'd0;
        end else if (hold_q == HOLD_LAST && m1_req) begin
          state_d = OWN1;
          last_d  = 1'b0;
          hold_d  = 4'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
          last_d  = 1'b1;
          hold_d  = 4'd0;
        end else if (hold_q == HOLD_LAST && m0_req) begin
          state_d = OWN0;
          last_d  = 1'b1;
          hold_d  = 4'd0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_d = wait_q;
    if (((m0_req & ~m0_gnt) | (m1_req & ~m1_gnt)) && wait_q != 16'hFFFF)
      wait_d = wait_q + 16'd1;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= 4'd0;
      wait_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: reset, single master, contention,
// owner release, mid-burst reset and wait counter saturation.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic        dram_we;
  logic [15:0] wait_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  always @(posedge clk) if (dram_we) mem[dram_addr[15:2]] <= dram_wdata;
  assign dram_rdata = mem[dram_addr[15:2]];

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .wait_cnt(wait_cnt)
  );

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h2;
    for (int i = 0; i < 2; i++) begin
      tick(); #4;
      total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_m0_gnt cyc%0d: got %b want 0", i, m0_gnt); end
      total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL reset_m1_gnt cyc%0d: got %b want 0", i, m1_gnt); end
      total++; if (dram_we !== 1'b0) begin bad++; $display("FAIL reset_dram_we cyc%0d: got %b want 0", i, dram_we); end
      total++; if (wait_cnt !== 16'd0) begin bad++; $display("FAIL reset_wait cyc%0d: got %0d want 0", i, wait_cnt); end
      total++; if (dram_addr !== 32'd0) begin bad++; $display("FAIL reset_dram_addr cyc%0d: got %h want 0", i, dram_addr); end
    end
    tick(); rst = 0; #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL reset_release_idle: got %b want 00", {m0_gnt, m1_gnt}); end
    tick(); #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL reset_first_tie: got %b want 10", {m0_gnt, m1_gnt}); end
    total++; if (wait_cnt !== 16'd1) begin bad++; $display("FAIL reset_first_wait: got %0d want 1", wait_cnt); end
    $display("test_reset complete");
  endtask

  task automatic test_single();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF;
    #4;
    total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL single_n_gnt: got %b want 0", m0_gnt); end
    total++; if (dram_we !== 1'b0) begin bad++; $display("FAIL single_n_we: got %b want 0", dram_we); end
    tick(); #4;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL single_n1_gnt: got %b want 1", m0_gnt); end
    total++; if (dram_we !== 1'b1) begin bad++; $display("FAIL single_n1_we: got %b want 1", dram_we); end
    total++; if (dram_addr !== 32'h100) begin bad++; $display("FAIL single_addr: got %h want 00000100", dram_addr); end
    total++; if (dram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata: got %h want deadbeef", dram_wdata); end
    total++; if (wait_cnt !== 16'd1) begin bad++; $display("FAIL single_wait: got %0d want 1", wait_cnt); end
    tick(); m0_we = 0; #4;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL single_rd_gnt: got %b want 1", m0_gnt); end
    total++; if (dram_we !== 1'b0) begin bad++; $display("FAIL single_rd_we: got %b want 0", dram_we); end
    total++; if (m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", m0_rdata); end
    tick(); idle_inputs();
    $display("test_single complete");
  endtask

  task automatic test_contention();
    logic exp0;
    do_reset();
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL cont_idle: got %b want 00", {m0_gnt, m1_gnt}); end
    for (int i = 0; i < 12; i++) begin
      tick(); #4;
      exp0 = ((i / 4) % 2) == 0;
      total++; if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin bad++; $display("FAIL cont_gnt cyc%0d: got %b want %b", i, {m0_gnt, m1_gnt}, {exp0, ~exp0}); end
      total++; if (dram_addr !== (exp0 ? 32'h10 : 32'h20)) begin bad++; $display("FAIL cont_addr cyc%0d: got %h want %h", i, dram_addr, exp0 ? 32'h10 : 32'h20); end
      total++; if (wait_cnt !== 16'(i + 1)) begin bad++; $display("FAIL cont_wait cyc%0d: got %0d want %0d", i, wait_cnt, i + 1); end
    end
    tick(); idle_inputs();
    $display("test_contention complete");
  endtask

  task automatic test_release();
    do_reset();
    m1_req = 1; m1_addr = 32'h30;
    tick(); m0_req = 1; m0_addr = 32'h34; #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL rel_own1_a: got %b want 01", {m0_gnt, m1_gnt}); end
    tick(); #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL rel_own1_b: got %b want 01", {m0_gnt, m1_gnt}); end
    tick(); m1_req = 0; #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL rel_drop: got %b want 00", {m0_gnt, m1_gnt}); end
    tick(); #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL rel_m0_takes: got %b want 10", {m0_gnt, m1_gnt}); end
    total++; if (dram_addr !== 32'h34) begin bad++; $display("FAIL rel_addr: got %h want 00000034", dram_addr); end
    tick(); idle_inputs();
    $display("test_release complete");
  endtask

  task automatic test_midreset();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h11111111;
    tick(); #4;
    total++; if ({m1_gnt, dram_we} !== 2'b11) begin bad++; $display("FAIL mid_first_wr: got %b want 11", {m1_gnt, dram_we}); end
    tick(); m1_addr = 32'h204; m1_wdata = 32'h22222222; #4;
    total++; if ({m1_gnt, dram_we} !== 2'b11) begin bad++; $display("FAIL mid_second_wr: got %b want 11", {m1_gnt, dram_we}); end
    tick(); rst = 1; m0_req = 1; m1_addr = 32'h208; m1_wdata = 32'h33333333; #4;
    total++; if ({m0_gnt, m1_gnt, dram_we} !== 3'b000) begin bad++; $display("FAIL mid_rst_cycle: got %b want 000", {m0_gnt, m1_gnt, dram_we}); end
    tick(); rst = 0; #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL mid_idle: got %b want 00", {m0_gnt, m1_gnt}); end
    total++; if (dram_addr !== 32'd0) begin bad++; $display("FAIL mid_idle_addr: got %h want 0", dram_addr); end
    total++; if (mem[32'h204 >> 2] !== 32'h22222222) begin bad++; $display("FAIL mid_burst_data: got %h want 22222222", mem[32'h204 >> 2]); end
    total++; if (mem[32'h208 >> 2] === 32'h33333333) begin bad++; $display("FAIL mid_no_partial: got %h want anything but 33333333", mem[32'h208 >> 2]); end
    tick(); #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL mid_tie_m0: got %b want 10", {m0_gnt, m1_gnt}); end
    tick(); idle_inputs();
    $display("test_midreset complete");
  endtask

  task automatic test_saturation();
    do_reset();
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 1000; i++) tick();
    #4;
    total++; if (wait_cnt !== 16'd1000) begin bad++; $display("FAIL sat_mid: got %0d want 1000", wait_cnt); end
    for (int i = 0; i < 69000; i++) tick();
    #4;
    total++; if (wait_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_end: got %h want ffff", wait_cnt); end
    tick(); idle_inputs();
    $display("test_saturation complete");
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_contention();
    test_release();
    test_midreset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
